// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (A - B, LSB first) with start/ready/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // Single full-subtractor cell working on the current LSBs of the shift registers.
  logic ai, bi, d_bit, br_nxt, last_bit;
  assign ai       = a_sh_q[0];
  assign bi       = b_sh_q[0];
  assign d_bit    = ai ^ bi ^ br_q;
  assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign overflow = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    ready    = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // diff fills from the MSB side so bit 0 lands at diff[0] after WIDTH shifts.
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nxt;
        if (last_bit) begin
          cnt_d    = '0;
          borrow_d = br_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = (ai ^ bi) & (ai ^ d_bit);
`endif
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Overflow checks are compiled in when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .diff     (diff),
    .borrow   (borrow),
    .done     (done)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is high.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic [7:0] ed, input logic eb);
    int lat;
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) break;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
  endtask

  task automatic after_done(input string tag, input logic [7:0] ed);
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    chk({tag, "_diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int pulses;
    int prev;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_overflow", 32'(overflow), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op("op200_55", 8'd200, 8'd55, 8'd145, 1'b0);
    after_done("op200_55", 8'd145);
    run_op("op5_10", 8'd5, 8'd10, 8'hFB, 1'b1);
    after_done("op5_10", 8'hFB);
    run_op("op0_0", 8'h00, 8'h00, 8'h00, 1'b0);
    after_done("op0_0", 8'h00);
    run_op("op0_ff", 8'h00, 8'hFF, 8'h01, 1'b1);
    after_done("op0_ff", 8'h01);

    // Abort mid-operation with an asynchronous reset.
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op("op10_01", 8'h10, 8'h01, 8'h0F, 1'b0);
    after_done("op10_01", 8'h0F);

    // start held high for 40 cycles; operands scrambled whenever not idle.
    start  = 1'b1;
    a      = 8'd100;
    b      = 8'd1;
    pulses = 0;
    prev   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        chk("held_diff", 32'(diff), 32'd99);
        if (prev >= 0) chk("held_period", 32'(i - prev), 32'd10);
        prev = i;
        pulses++;
      end
      if (ready) begin
        a = 8'd100;
        b = 8'd1;
      end else begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pulses), 32'd4);
    repeat (12) @(negedge clk);
    chk("held_idle", 32'(ready), 32'd1);

    // A second start during BUSY must be ignored.
    start = 1'b1;
    a     = 8'h30;
    b     = 8'h10;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hFF;
    b     = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        pulses++;
        chk("ignore_diff", 32'(diff), 32'h20);
      end
      @(negedge clk);
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op("ovf80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
    chk("ovf80_01_overflow", 32'(overflow), 32'd1);
    after_done("ovf80_01", 8'h7F);
    run_op("ovf7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1);
    chk("ovf7f_ff_overflow", 32'(overflow), 32'd1);
    after_done("ovf7f_ff", 8'h80);
    run_op("ovf05_03", 8'h05, 8'h03, 8'h02, 1'b0);
    chk("ovf05_03_overflow", 32'(overflow), 32'd0);
    after_done("ovf05_03", 8'h02);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
